// File: rtl/fifo_mmio_bridge_pkg.sv
// Shared register map for the MMIO/USB-CDC FIFO bridge.
// Address constants and bit positions are used by the RTL decode and by firmware headers.
// No logic lives here apart from one small threshold-compare helper.
package fifo_mmio_bridge_pkg;

  // Register indices on addr_i
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  // STATUS bit positions
  localparam int STATUS_RX_COUNT_LSB = 0;
  localparam int STATUS_TX_FREE_LSB  = 16;
  localparam int STATUS_RX_EMPTY     = 25;
  localparam int STATUS_TX_FULL      = 26;

  // CTRL bit positions
  localparam int CTRL_RX_IRQ_EN     = 0;
  localparam int CTRL_TX_IRQ_EN     = 1;
  localparam int CTRL_ERR_IRQ_EN    = 2;
  localparam int CTRL_RX_THRESH_LSB = 8;
  localparam int CTRL_TX_THRESH_LSB = 16;
  localparam int CTRL_FLUSH         = 31;

  // IRQ bit positions
  localparam int IRQ_RX_LVL = 0;
  localparam int IRQ_TX_LVL = 1;
  localparam int IRQ_TX_OVF = 2;
  localparam int IRQ_RX_UDF = 3;

  // Field widths: levels cover 0..256, thresholds are one byte
  localparam int LEVEL_W  = 9;
  localparam int THRESH_W = 8;

  // Stored CTRL fields; the flush bit is an action, never stored
  typedef struct packed {
    logic [THRESH_W-1:0] tx_thresh;
    logic [THRESH_W-1:0] rx_thresh;
    logic                err_irq_en;
    logic                tx_irq_en;
    logic                rx_irq_en;
  } ctrl_t;

  // A threshold of zero disables the level indication entirely
  function automatic logic level_hit(input logic [LEVEL_W-1:0]  level,
                                     input logic [THRESH_W-1:0] thresh);
    return (thresh != '0) && (level >= {1'b0, thresh});
  endfunction

endpackage

// File: rtl/fifo_mmio_bridge_sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through head, single-cycle flush.
// Latency: a pushed word appears on head_dat the cycle after its push edge.
// Backpressure: push ignored while full, pop ignored while empty; flush overrides both.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Qualified operations; flush discards anything presented in the same cycle
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;

  // Head reads as zero while empty so downstream never sees stale storage
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fifo_mmio_bridge.sv
// Memory-mapped bridge between CPU loads/stores and the USB CDC byte streams (TX and RX FIFOs).
// Latency: register reads land on data_o one edge after sel&read; TX bytes are fall-through.
// Backpressure: TX waits on in_ready_i, RX deasserts out_ready_o when full; CPU overruns set sticky flags.
module fifo_mmio_bridge
  import fifo_mmio_bridge_pkg::*;
#(
  parameter int TX_DEPTH      = 16,
  parameter int RX_DEPTH      = 16,
  parameter int BUS_W         = 32,
  parameter int RX_THRESH_RST = 1,
  parameter int TX_THRESH_RST = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             sel_i,
  input  logic             read_i,
  input  logic             write_i,
  input  logic [1:0]       addr_i,
  input  logic [BUS_W-1:0] data_i,
  output logic [BUS_W-1:0] data_o,
  output logic             rx_irq_o,
  output logic             tx_irq_o,
  output logic             err_irq_o,
  output logic [7:0]       in_data_o,
  output logic             in_valid_o,
  input  logic             in_ready_i,
  input  logic [7:0]       out_data_i,
  input  logic             out_valid_i,
  output logic             out_ready_o
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  // ---------------------------------------------------------------
  // Bus decode. A simultaneous read and write is treated as a write.
  // ---------------------------------------------------------------
  logic bus_wr;
  logic bus_rd;
  logic data_wr;
  logic data_rd;
  logic ctrl_wr;
  logic irq_wr;
  logic flush;

  assign bus_wr  = sel_i & write_i;
  assign bus_rd  = sel_i & read_i & ~write_i;
  assign data_wr = bus_wr & (addr_i == REG_DATA);
  assign data_rd = bus_rd & (addr_i == REG_DATA);
  assign ctrl_wr = bus_wr & (addr_i == REG_CTRL);
  assign irq_wr  = bus_wr & (addr_i == REG_IRQ);
  assign flush   = ctrl_wr & data_i[CTRL_FLUSH];

  // Only a handful of data_i bits are architecturally meaningful
  logic unused_data;
  assign unused_data = ^data_i;

  // ---------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------
  logic             tx_full;
  logic             tx_empty;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       tx_head;
  logic             tx_push;
  logic             tx_pop;

  logic             rx_full;
  logic             rx_empty;
  logic [RX_CW-1:0] rx_count;
  logic [7:0]       rx_head;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_rdy_en;

  assign tx_push = data_wr & ~tx_full;
  assign tx_pop  = in_valid_o & in_ready_i;
  assign rx_push = out_valid_i & out_ready_o;
  assign rx_pop  = data_rd & ~rx_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .push     (tx_push),
    .push_dat (data_i[7:0]),
    .pop      (tx_pop),
    .flush    (flush),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_count),
    .head_dat (tx_head)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .push     (rx_push),
    .push_dat (out_data_i),
    .pop      (rx_pop),
    .flush    (flush),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_count),
    .head_dat (rx_head)
  );

  // USB-facing handshakes
  assign in_valid_o  = ~tx_empty;
  assign in_data_o   = tx_head;
  assign out_ready_o = rx_rdy_en & ~rx_full;

  // Hold out_ready_o low through reset and for the first edge after release
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rx_rdy_en <= 1'b0;
    else         rx_rdy_en <= 1'b1;
  end

  // ---------------------------------------------------------------
  // Levels seen by software
  // ---------------------------------------------------------------
  logic [LEVEL_W-1:0] rx_level;
  logic [LEVEL_W-1:0] tx_free;
  logic               rx_lvl;
  logic               tx_lvl;
  ctrl_t              ctrl_q;

  assign rx_level = LEVEL_W'(rx_count);
  assign tx_free  = LEVEL_W'(TX_DEPTH) - LEVEL_W'(tx_count);
  assign rx_lvl   = level_hit(rx_level, ctrl_q.rx_thresh);
  assign tx_lvl   = level_hit(tx_free,  ctrl_q.tx_thresh);

  // CTRL register: enables and thresholds; the flush bit acts but is not stored
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_q.rx_irq_en  <= 1'b0;
      ctrl_q.tx_irq_en  <= 1'b0;
      ctrl_q.err_irq_en <= 1'b0;
      ctrl_q.rx_thresh  <= THRESH_W'(RX_THRESH_RST);
      ctrl_q.tx_thresh  <= THRESH_W'(TX_THRESH_RST);
    end else if (ctrl_wr) begin
      ctrl_q.rx_irq_en  <= data_i[CTRL_RX_IRQ_EN];
      ctrl_q.tx_irq_en  <= data_i[CTRL_TX_IRQ_EN];
      ctrl_q.err_irq_en <= data_i[CTRL_ERR_IRQ_EN];
      ctrl_q.rx_thresh  <= data_i[CTRL_RX_THRESH_LSB +: THRESH_W];
      ctrl_q.tx_thresh  <= data_i[CTRL_TX_THRESH_LSB +: THRESH_W];
    end
  end

  // ---------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------
  logic tx_ovf_q;
  logic rx_udf_q;
  logic tx_ovf_set;
  logic rx_udf_set;

  // A DATA write into a full TX FIFO is dropped; flush losses are not errors
  assign tx_ovf_set = data_wr & tx_full & ~flush;
  assign rx_udf_set = data_rd & rx_empty;

  // Write-1-to-clear, with a same-cycle set taking priority over the clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~(irq_wr & data_i[IRQ_TX_OVF]));
      rx_udf_q <= rx_udf_set | (rx_udf_q & ~(irq_wr & data_i[IRQ_RX_UDF]));
    end
  end

  // Interrupts are pure functions of registered state
  assign rx_irq_o  = ctrl_q.rx_irq_en  & rx_lvl;
  assign tx_irq_o  = ctrl_q.tx_irq_en  & tx_lvl;
  assign err_irq_o = ctrl_q.err_irq_en & (tx_ovf_q | rx_udf_q);

  // ---------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------
  logic [31:0] rd_word;

  // Select the register image for the addressed index; unused bits stay zero
  always_comb begin
    rd_word = '0;
    case (addr_i)
      REG_DATA: begin
        if (!rx_empty) rd_word[7:0] = rx_head;
      end
      REG_STATUS: begin
        rd_word[STATUS_RX_COUNT_LSB +: LEVEL_W] = rx_level;
        rd_word[STATUS_TX_FREE_LSB  +: LEVEL_W] = tx_free;
        rd_word[STATUS_RX_EMPTY]                = rx_empty;
        rd_word[STATUS_TX_FULL]                 = tx_full;
      end
      REG_CTRL: begin
        rd_word[CTRL_RX_IRQ_EN]                     = ctrl_q.rx_irq_en;
        rd_word[CTRL_TX_IRQ_EN]                     = ctrl_q.tx_irq_en;
        rd_word[CTRL_ERR_IRQ_EN]                    = ctrl_q.err_irq_en;
        rd_word[CTRL_RX_THRESH_LSB +: THRESH_W]     = ctrl_q.rx_thresh;
        rd_word[CTRL_TX_THRESH_LSB +: THRESH_W]     = ctrl_q.tx_thresh;
      end
      REG_IRQ: begin
        rd_word[IRQ_RX_LVL] = rx_lvl;
        rd_word[IRQ_TX_LVL] = tx_lvl;
        rd_word[IRQ_TX_OVF] = tx_ovf_q;
        rd_word[IRQ_RX_UDF] = rx_udf_q;
      end
      default: rd_word = '0;
    endcase
  end

  // Registered read data; holds between reads
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)     data_o <= '0;
    else if (bus_rd) data_o <= BUS_W'(rd_word);
  end

endmodule

// File: tb/tb_fifo_mmio_bridge.sv
module tb_fifo_mmio_bridge;
  import fifo_mmio_bridge_pkg::*;

  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        sel_i = 1'b0, read_i = 1'b0, write_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        rx_irq_o, tx_irq_o, err_irq_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i = 1'b0;
  logic [7:0]  out_data_i = 8'd0;
  logic        out_valid_i = 1'b0;
  logic        out_ready_o;

  int checks = 0;
  int errors = 0;

  fifo_mmio_bridge #(
    .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .BUS_W(32),
    .RX_THRESH_RST(1), .TX_THRESH_RST(1)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sel_i(sel_i), .read_i(read_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .rx_irq_o(rx_irq_o), .tx_irq_o(tx_irq_o), .err_irq_o(err_irq_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    sel_i = 0; read_i = 0; write_i = 0; addr_i = 0; data_i = 0;
    in_ready_i = 0; out_valid_i = 0; out_data_i = 0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel_i = 1; write_i = 1; read_i = 0; addr_i = a; data_i = d;
    tick();
    sel_i = 0; write_i = 0; data_i = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel_i = 1; read_i = 1; write_i = 0; addr_i = a;
    tick();
    d = data_o;
    sel_i = 0; read_i = 0;
  endtask

  task automatic usb_push(input logic [7:0] b);
    out_valid_i = 1; out_data_i = b;
    tick();
    out_valid_i = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop immediately
  task automatic do_reset();
    #2;
    rstn_i = 0;
    idle_inputs();
    #1;
    check("rst_data_o",   data_o, 0);
    check("rst_in_valid", {31'd0, in_valid_o}, 0);
    check("rst_in_data",  {24'd0, in_data_o}, 0);
    check("rst_out_rdy",  {31'd0, out_ready_o}, 0);
    check("rst_irqs",     {29'd0, err_irq_o, tx_irq_o, rx_irq_o}, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1;
    tick();
    check("rst_out_rdy_after", {31'd0, out_ready_o}, 1);
  endtask

  // ---------------------------------------------------------------
  // Behavioural model: queues plus flags, updated per cycle
  // ---------------------------------------------------------------
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  bit         m_ovf, m_udf, m_rx_en, m_tx_en, m_err_en;
  int         m_rx_th, m_tx_th;
  logic [31:0] m_dato;

  function automatic bit m_rx_lvl();
    return (m_rx_th != 0) && (m_rx.size() >= m_rx_th);
  endfunction

  function automatic bit m_tx_lvl();
    return (m_tx_th != 0) && ((TX_DEPTH - m_tx.size()) >= m_tx_th);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    int rxc, txf;
    logic [31:0] r;
    rxc = m_rx.size();
    txf = TX_DEPTH - m_tx.size();
    r = 0;
    case (a)
      REG_DATA:   r = (rxc == 0) ? 32'd0 : {24'd0, m_rx[0]};
      REG_STATUS: r = 32'(rxc) + 32'(txf) * 65536 + ((rxc == 0) ? 32'h0200_0000 : 0)
                      + ((txf == 0) ? 32'h0400_0000 : 0);
      REG_CTRL:   r = 32'(m_rx_en) + 32'(m_tx_en) * 2 + 32'(m_err_en) * 4
                      + 32'(m_rx_th) * 256 + 32'(m_tx_th) * 65536;
      default:    r = 32'(m_rx_lvl()) + 32'(m_tx_lvl()) * 2 + 32'(m_ovf) * 4 + 32'(m_udf) * 8;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------
  typedef struct {
    logic        sel, rd, wr;
    logic [1:0]  addr;
    logic [31:0] wdat;
    logic [31:0] exp_dat;
    logic        exp_in_vld;
    logic        exp_out_rdy;
    logic [2:0]  exp_irq;   // {err, tx, rx}
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] d;
    int rdy_pct, vld_pct;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, REG_STATUS, 32'h0,         32'h0210_0000, 1'b0, 1'b1, 3'b000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, REG_CTRL,   32'h0,         32'h0001_0100, 1'b0, 1'b1, 3'b000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, REG_IRQ,    32'h0,         32'h0000_0002, 1'b0, 1'b1, 3'b000};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, REG_CTRL,   32'h8003_0307, 32'h0000_0002, 1'b0, 1'b1, 3'b010};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, REG_CTRL,   32'h0,         32'h0003_0307, 1'b0, 1'b1, 3'b010};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, REG_STATUS, 32'h0,         32'h0003_0307, 1'b0, 1'b1, 3'b010};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, REG_DATA,   32'h41,        32'h0003_0307, 1'b1, 1'b1, 3'b010};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, REG_STATUS, 32'h0,         32'h020F_0000, 1'b1, 1'b1, 3'b010};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, REG_DATA,   32'h0,         32'h0000_0000, 1'b1, 1'b1, 3'b110};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, REG_IRQ,    32'h0,         32'h0000_000A, 1'b1, 1'b1, 3'b110};
    vecs[10] = '{1'b1, 1'b0, 1'b1, REG_IRQ,    32'h8,         32'h0000_000A, 1'b1, 1'b1, 3'b010};
    vecs[11] = '{1'b1, 1'b1, 1'b0, REG_IRQ,    32'h0,         32'h0000_0002, 1'b1, 1'b1, 3'b010};
    vecs[12] = '{1'b0, 1'b0, 1'b1, REG_DATA,   32'h99,        32'h0000_0002, 1'b1, 1'b1, 3'b010};
    vecs[13] = '{1'b1, 1'b1, 1'b0, REG_STATUS, 32'h0,         32'h020F_0000, 1'b1, 1'b1, 3'b010};

    do_reset();

    for (int i = 0; i < 14; i++) begin
      sel_i = vecs[i].sel; read_i = vecs[i].rd; write_i = vecs[i].wr;
      addr_i = vecs[i].addr; data_i = vecs[i].wdat;
      tick();
      check($sformatf("vec%0d_data_o", i), data_o, vecs[i].exp_dat);
      check($sformatf("vec%0d_in_vld", i), {31'd0, in_valid_o}, {31'd0, vecs[i].exp_in_vld});
      check($sformatf("vec%0d_out_rdy", i), {31'd0, out_ready_o}, {31'd0, vecs[i].exp_out_rdy});
      check($sformatf("vec%0d_irqs", i), {29'd0, err_irq_o, tx_irq_o, rx_irq_o},
            {29'd0, vecs[i].exp_irq});
    end
    idle_inputs();

    // Reset while a TX byte is pending
    check("pre_rst_in_vld", {31'd0, in_valid_o}, 1);
    do_reset();

    // TX ordering through the fall-through head
    bus_write(REG_DATA, 32'h41);
    bus_write(REG_DATA, 32'h42);
    check("txa_vld_held", {31'd0, in_valid_o}, 1);
    check("txa_head0", {24'd0, in_data_o}, 32'h41);
    in_ready_i = 1;
    tick();
    check("txa_head1", {24'd0, in_data_o}, 32'h42);
    check("txa_vld1", {31'd0, in_valid_o}, 1);
    tick();
    check("txa_drained", {31'd0, in_valid_o}, 0);
    in_ready_i = 0;

    // RX fill to capacity, refused 17th byte, ordered drain
    for (int i = 0; i < RX_DEPTH; i++) begin
      check($sformatf("rxb_rdy%0d", i), {31'd0, out_ready_o}, 1);
      usb_push(8'(i));
    end
    check("rxb_full_rdy", {31'd0, out_ready_o}, 0);
    out_valid_i = 1; out_data_i = 8'hEE;
    tick();
    tick();
    out_valid_i = 0;
    check("rxb_still_full", {31'd0, out_ready_o}, 0);
    bus_read(REG_STATUS, d);
    check("rxb_status_full", d, 32'h0010_0010);
    for (int i = 0; i < RX_DEPTH; i++) begin
      bus_read(REG_DATA, d);
      check($sformatf("rxb_byte%0d", i), d, 32'(i));
    end
    bus_read(REG_STATUS, d);
    check("rxb_status_empty", d, 32'h0210_0000);

    // TX overflow, sticky flag, error interrupt, W1C
    bus_write(REG_CTRL, 32'h0001_0104);
    for (int i = 0; i < TX_DEPTH; i++) bus_write(REG_DATA, 32'h10 + 32'(i));
    bus_read(REG_STATUS, d);
    check("txc_status_full", d, 32'h0600_0000);
    check("txc_err_before", {31'd0, err_irq_o}, 0);
    bus_write(REG_DATA, 32'hFF);
    bus_read(REG_IRQ, d);
    check("txc_irq_ovf", d, 32'h4);
    check("txc_err_irq", {31'd0, err_irq_o}, 1);
    bus_write(REG_IRQ, 32'h4);
    check("txc_err_cleared", {31'd0, err_irq_o}, 0);
    bus_read(REG_IRQ, d);
    check("txc_irq_clear", d, 32'h0);
    in_ready_i = 1;
    for (int i = 0; i < TX_DEPTH; i++) begin
      check($sformatf("txc_byte%0d", i), {23'd0, in_valid_o, in_data_o}, 32'h100 + 32'h10 + 32'(i));
      tick();
    end
    check("txc_drop_lost", {31'd0, in_valid_o}, 0);
    in_ready_i = 0;

    // RX threshold interrupt
    bus_write(REG_CTRL, 32'h0001_0301);
    usb_push(8'hA0);
    usb_push(8'hA1);
    check("thr_below", {31'd0, rx_irq_o}, 0);
    usb_push(8'hA2);
    check("thr_reached", {31'd0, rx_irq_o}, 1);
    bus_read(REG_DATA, d);
    check("thr_read_byte", d, 32'hA0);
    check("thr_dropped", {31'd0, rx_irq_o}, 0);

    // Flush with both FIFOs partly full and a concurrent RX byte
    do_reset();
    for (int i = 0; i < 5; i++) usb_push(8'h60 + 8'(i));
    for (int i = 0; i < 5; i++) bus_write(REG_DATA, 32'h70 + 32'(i));
    bus_read(REG_STATUS, d);
    check("fl_status_pre", d, 32'h000B_0005);
    out_valid_i = 1; out_data_i = 8'h77;
    bus_write(REG_CTRL, 32'h8001_0100);
    out_valid_i = 0;
    check("fl_in_vld", {31'd0, in_valid_o}, 0);
    bus_read(REG_STATUS, d);
    check("fl_status_post", d, 32'h0210_0000);
    bus_read(REG_CTRL, d);
    check("fl_ctrl_read", d, 32'h0001_0100);
    bus_read(REG_DATA, d);
    check("fl_data_udf", d, 32'h0);
    bus_read(REG_IRQ, d);
    check("fl_irq_udf", d, 32'hA);

    // Randomized traffic against the queue model
    do_reset();
    m_tx.delete(); m_rx.delete();
    m_ovf = 0; m_udf = 0; m_rx_en = 0; m_tx_en = 0; m_err_en = 0;
    m_rx_th = 1; m_tx_th = 1; m_dato = 0;
    rdy_pct = 50; vld_pct = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit cpu_wr, cpu_rd, flush;
      int tx_pre, rx_pre;
      if (cyc % 500 == 0) begin
        rdy_pct = ((cyc / 500) % 2 == 1) ? 10 : 70;
        vld_pct = ((cyc / 500) % 3) * 35 + 5;
      end
      sel_i   = ($urandom_range(0, 9) != 0);
      read_i  = 1'($urandom_range(0, 1));
      write_i = ($urandom_range(0, 2) == 0);
      addr_i  = ($urandom_range(0, 1) == 1) ? REG_DATA : 2'($urandom_range(0, 3));
      data_i  = $urandom;
      if (addr_i == REG_CTRL) begin
        data_i[15:8]  = 8'($urandom_range(0, RX_DEPTH + 1));
        data_i[23:16] = 8'($urandom_range(0, TX_DEPTH + 1));
        if ($urandom_range(0, 15) != 0) data_i[31] = 1'b0;
      end
      in_ready_i  = ($urandom_range(0, 99) < rdy_pct);
      out_valid_i = ($urandom_range(0, 99) < vld_pct);
      out_data_i  = 8'($urandom);

      @(negedge clk_i);
      check("rnd_in_vld", {31'd0, in_valid_o}, {31'd0, m_tx.size() > 0});
      if (m_tx.size() > 0) check("rnd_in_data", {24'd0, in_data_o}, {24'd0, m_tx[0]});
      check("rnd_out_rdy", {31'd0, out_ready_o}, {31'd0, m_rx.size() < RX_DEPTH});
      check("rnd_irqs", {29'd0, err_irq_o, tx_irq_o, rx_irq_o},
            {29'd0, m_err_en && (m_ovf || m_udf), m_tx_en && m_tx_lvl(), m_rx_en && m_rx_lvl()});

      cpu_wr = sel_i && write_i;
      cpu_rd = sel_i && read_i && !write_i;
      flush  = cpu_wr && addr_i == REG_CTRL && data_i[31];
      tx_pre = m_tx.size();
      rx_pre = m_rx.size();
      if (cpu_rd) m_dato = model_read(addr_i);
      if (cpu_wr && addr_i == REG_IRQ) begin
        if (data_i[2]) m_ovf = 0;
        if (data_i[3]) m_udf = 0;
      end
      if (cpu_wr && addr_i == REG_CTRL) begin
        m_rx_en = data_i[0]; m_tx_en = data_i[1]; m_err_en = data_i[2];
        m_rx_th = int'(data_i[15:8]); m_tx_th = int'(data_i[23:16]);
      end
      if (flush) begin
        m_tx.delete();
        m_rx.delete();
      end else begin
        if (in_ready_i && tx_pre > 0) void'(m_tx.pop_front());
        if (cpu_wr && addr_i == REG_DATA) begin
          if (tx_pre == TX_DEPTH) m_ovf = 1;
          else m_tx.push_back(data_i[7:0]);
        end
        if (cpu_rd && addr_i == REG_DATA) begin
          if (rx_pre == 0) m_udf = 1;
          else void'(m_rx.pop_front());
        end
        if (out_valid_i && rx_pre < RX_DEPTH) m_rx.push_back(out_data_i);
      end

      @(posedge clk_i);
      #1;
      check("rnd_data_o", data_o, m_dato);
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
